// File: rtl/if_pc_gen_pkg.sv
// Shared constants for the instruction-fetch PC generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package if_pc_gen_pkg;

    // Reset level and chip-enable levels of the instruction memory interface
    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Default instruction address bus width
    localparam int InstAddrBus = 32;

    // Fetch FSM encodings
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/if_redirect_sel.sv
// Next-PC target select: trap > redirect > pending, plus sequential pc+STEP.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a selected target is loaded.
module if_redirect_sel #(
    parameter int ADDR_W     = 32,
    parameter int STEP       = 4,
    parameter int ALIGN_BITS = 2
) (
    input  logic              i_trap_vld,
    input  logic [ADDR_W-1:0] i_trap_pc,
    input  logic              i_redir_vld,
    input  logic [ADDR_W-1:0] i_redir_pc,
    input  logic              i_pend_vld,
    input  logic [ADDR_W-1:0] i_pend_pc,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_hit_now,
    output logic              o_tgt_vld,
    output logic [ADDR_W-1:0] o_tgt_pc,
    output logic              o_tgt_mis,
    output logic [ADDR_W-1:0] o_seq_pc
);

    // Low bits that must be zero in any fetch address
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] w_raw;

    // Raw (unaligned) target: a trap beats a redirect, both beat the pending entry
    always_comb begin
        w_raw = i_pend_pc;
        if (i_trap_vld) begin
            w_raw = i_trap_pc;
        end else if (i_redir_vld) begin
            w_raw = i_redir_pc;
        end
    end

    assign o_hit_now = i_trap_vld | i_redir_vld;
    assign o_tgt_vld = o_hit_now | i_pend_vld;
    assign o_tgt_pc  = w_raw & ~LOW_MASK;
    assign o_tgt_mis = |(w_raw & LOW_MASK);
    // Wraps modulo 2^ADDR_W on purpose; running off the top of memory is not an error
    assign o_seq_pc  = i_pc + ADDR_W'(STEP);

endmodule

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: drives pc/ce, advances on mem_ack_i, applies trap/branch redirects.
// Latency: new pc visible the cycle after the acknowledge; kill_o is same-cycle with the ack.
// Backpressure: no ack keeps pc/ce stable and parks redirects in a one-entry pending register; stall_i parks in HOLD.
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                STEP         = 4,
    parameter int                ALIGN_BITS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_pc_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              kill_o,
    output logic              misalign_o
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic              r_misalign;
    logic              r_pend_vld;
    logic              r_pend_trap;
    logic [ADDR_W-1:0] r_pend_pc;

    logic              w_hit_now;
    logic              w_tgt_vld;
    logic [ADDR_W-1:0] w_tgt_pc;
    logic              w_tgt_mis;
    logic [ADDR_W-1:0] w_seq_pc;
    logic              w_fetch_ack;

    if_redirect_sel #(
        .ADDR_W     (ADDR_W),
        .STEP       (STEP),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_sel (
        .i_trap_vld  (trap_valid_i),
        .i_trap_pc   (trap_pc_i),
        .i_redir_vld (redirect_valid_i),
        .i_redir_pc  (redirect_pc_i),
        .i_pend_vld  (r_pend_vld),
        .i_pend_pc   (r_pend_pc),
        .i_pc        (r_pc),
        .o_hit_now   (w_hit_now),
        .o_tgt_vld   (w_tgt_vld),
        .o_tgt_pc    (w_tgt_pc),
        .o_tgt_mis   (w_tgt_mis),
        .o_seq_pc    (w_seq_pc)
    );

    // Acks only count while a request is actually outstanding
    assign w_fetch_ack = (r_state == FETCH) && mem_ack_i;

    assign pc         = r_pc;
    assign ce         = r_ce;
    assign misalign_o = r_misalign;
    assign kill_o     = w_fetch_ack && w_tgt_vld;

    // Fetch FSM with pc/ce registers; misalign pulses for one cycle after a target load
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_ce       <= ChipDisable;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                    r_pc    <= RESET_VECTOR;
                    r_ce    <= ChipEnable;
                end
                FETCH: begin
                    if (mem_ack_i) begin
                        if (w_tgt_vld) begin
                            r_pc       <= w_tgt_pc;
                            r_misalign <= w_tgt_mis;
                        end else if (stall_i) begin
                            r_state <= HOLD;
                            r_ce    <= ChipDisable;
                        end else begin
                            r_pc <= w_seq_pc;
                        end
                    end
                end
                HOLD: begin
                    // Pending is always empty here, so only a same-cycle trap/redirect can hit
                    if (w_tgt_vld) begin
                        r_pc       <= w_tgt_pc;
                        r_misalign <= w_tgt_mis;
                        r_state    <= FETCH;
                        r_ce       <= ChipEnable;
                    end else if (!stall_i) begin
                        r_pc    <= w_seq_pc;
                        r_state <= FETCH;
                        r_ce    <= ChipEnable;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_ce    <= ChipDisable;
                end
            endcase
        end
    end

    // Pending redirect: park trap/redirect until the outstanding fetch is acked.
    // A trap always overwrites; a redirect never displaces a parked trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_pend_vld  <= 1'b0;
            r_pend_trap <= 1'b0;
            r_pend_pc   <= {ADDR_W{1'b0}};
        end else if (w_fetch_ack) begin
            r_pend_vld  <= 1'b0;
            r_pend_trap <= 1'b0;
        end else if (r_state != HOLD) begin
            if (trap_valid_i) begin
                r_pend_vld  <= 1'b1;
                r_pend_trap <= 1'b1;
                r_pend_pc   <= trap_pc_i;
            end else if (redirect_valid_i && !(r_pend_vld && r_pend_trap)) begin
                r_pend_vld  <= 1'b1;
                r_pend_trap <= 1'b0;
                r_pend_pc   <= redirect_pc_i;
            end
        end
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: table of per-cycle vectors plus hand sequences.
// Latency: outputs checked each cycle after the inputs settle, before the next posedge.
// Backpressure: exercised via mem_ack_i low, stall_i and pending redirects.
module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic        tv = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] tpc = '0;

    logic [31:0] a_pc;
    logic        a_ce, a_kill, a_mis;
    logic [31:0] b_pc;
    logic        b_ce, b_kill, b_mis;
    logic [15:0] c_pc;
    logic        c_ce, c_kill, c_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // A: defaults; B: 2-byte alignment; C: 16-bit address near the top of memory
    if_pc_gen u_a (
        .clk(clk), .rst(rst), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_pc_i(rpc),
        .trap_valid_i(tv), .trap_pc_i(tpc), .mem_ack_i(ack),
        .pc(a_pc), .ce(a_ce), .kill_o(a_kill), .misalign_o(a_mis)
    );

    if_pc_gen #(.ALIGN_BITS(1)) u_b (
        .clk(clk), .rst(rst), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_pc_i(rpc),
        .trap_valid_i(tv), .trap_pc_i(tpc), .mem_ack_i(ack),
        .pc(b_pc), .ce(b_ce), .kill_o(b_kill), .misalign_o(b_mis)
    );

    if_pc_gen #(.ADDR_W(16), .RESET_VECTOR(16'hFFF8)) u_c (
        .clk(clk), .rst(rst), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_pc_i(rpc[15:0]),
        .trap_valid_i(tv), .trap_pc_i(tpc[15:0]), .mem_ack_i(ack),
        .pc(c_pc), .ce(c_ce), .kill_o(c_kill), .misalign_o(c_mis)
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        tv;
        logic [31:0] tpc;
        logic        ack;
        logic [31:0] pc;
        logic        ce;
        logic        kill;
        logic        mis;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic t, input logic [31:0] tp, input logic a,
                                input logic [31:0] p, input logic c, input logic k,
                                input logic m);
        vec_t v;
        v.stall = s; v.rv = r; v.rpc = rp; v.tv = t; v.tpc = tp; v.ack = a;
        v.pc = p; v.ce = c; v.kill = k; v.mis = m;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let them settle
    task automatic apply(input logic s, input logic r, input logic [31:0] rp,
                         input logic t, input logic [31:0] tp, input logic a);
        @(negedge clk);
        stall = s; rv = r; rpc = rp; tv = t; tpc = tp; ack = a;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; rv = 1'b0; tv = 1'b0; ack = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        //            stall rv rpc     tv tpc     ack   pc      ce kill mis
        vt[0]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h000, 0, 0, 0);
        vt[1]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h000, 1, 0, 0);
        vt[2]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h004, 1, 0, 0);
        vt[3]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h008, 1, 0, 0);
        vt[4]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h00C, 1, 0, 0);
        vt[5]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h010, 1, 0, 0);
        vt[6]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 0, 0);
        vt[7]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 0, 0);
        vt[8]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 0, 0);
        vt[9]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h014, 1, 0, 0);
        vt[10] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h018, 1, 0, 0);
        vt[11] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h01C, 1, 0, 0);
        vt[12] = mk(0, 1, 32'h200, 0, 32'h0,   0, 32'h020, 1, 0, 0);
        vt[13] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h020, 1, 0, 0);
        vt[14] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h020, 1, 1, 0);
        vt[15] = mk(0, 1, 32'h300, 1, 32'h080, 1, 32'h200, 1, 1, 0);
        vt[16] = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h080, 1, 0, 0);
        vt[17] = mk(0, 1, 32'h400, 0, 32'h0,   0, 32'h080, 1, 0, 0);
        vt[18] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h080, 1, 1, 0);
        vt[19] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 0, 0);
        vt[20] = mk(0, 1, 32'h203, 0, 32'h0,   1, 32'h104, 1, 1, 0);
        vt[21] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 1, 0, 1);
        vt[22] = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h204, 1, 0, 0);
        vt[23] = mk(1, 1, 32'h500, 0, 32'h0,   1, 32'h204, 0, 0, 0);
        vt[24] = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h500, 1, 0, 0);
        vt[25] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 1, 0, 0);
        vt[26] = mk(0, 1, 32'h600, 0, 32'h0,   0, 32'h504, 1, 0, 0);
        vt[27] = mk(0, 1, 32'h700, 0, 32'h0,   0, 32'h504, 1, 0, 0);
        vt[28] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h504, 1, 1, 0);
        vt[29] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h700, 1, 0, 0);

        // Reset state while rst is held
        @(negedge clk);
        #1;
        chk("rst_pc",   0, a_pc,   32'h0);
        chk("rst_ce",   0, 32'(a_ce),   32'h0);
        chk("rst_kill", 0, 32'(a_kill), 32'h0);
        chk("rst_mis",  0, 32'(a_mis),  32'h0);
        chk("rst_c_pc", 0, 32'(c_pc),   32'hFFF8);
        @(posedge clk);
        #2 rst = 1'b0;

        // Main table on the default-parameter instance
        for (int i = 0; i < NV; i++) begin
            apply(vt[i].stall, vt[i].rv, vt[i].rpc, vt[i].tv, vt[i].tpc, vt[i].ack);
            chk("pc",   i, a_pc,             vt[i].pc);
            chk("ce",   i, 32'(a_ce),        32'(vt[i].ce));
            chk("kill", i, 32'(a_kill),      32'(vt[i].kill));
            chk("mis",  i, 32'(a_mis),       32'(vt[i].mis));
        end

        // Misaligned target with 1-bit vs 2-bit alignment
        do_reset();
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        apply(0, 1, 32'h203, 0, 32'h0, 1);
        chk("b_kill", 100, 32'(b_kill), 32'h1);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("b_pc",   101, b_pc,        32'h202);
        chk("b_mis",  101, 32'(b_mis),  32'h1);
        chk("a_pc",   101, a_pc,        32'h200);
        chk("a_mis",  101, 32'(a_mis),  32'h1);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("b_pc",   102, b_pc,        32'h206);
        chk("b_mis",  102, 32'(b_mis),  32'h0);
        chk("a_pc",   102, a_pc,        32'h204);

        // 16-bit wrap at the top of memory, then reset mid-fetch
        do_reset();
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("c_pc",   200, 32'(c_pc),   32'hFFF8);
        chk("c_ce",   200, 32'(c_ce),   32'h0);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("c_pc",   201, 32'(c_pc),   32'hFFF8);
        chk("c_ce",   201, 32'(c_ce),   32'h1);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("c_pc",   202, 32'(c_pc),   32'hFFFC);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        chk("c_pc",   203, 32'(c_pc),   32'h0000);
        chk("c_ce",   203, 32'(c_ce),   32'h1);
        chk("c_mis",  203, 32'(c_mis),  32'h0);
        chk("a_pc",   203, a_pc,        32'h8);
        @(negedge clk);
        rst = 1'b1; rv = 1'b1; rpc = 32'h40; ack = 1'b1;
        #1;
        chk("c_rst_pc",   204, 32'(c_pc),   32'hFFF8);
        chk("c_rst_ce",   204, 32'(c_ce),   32'h0);
        chk("c_rst_kill", 204, 32'(c_kill), 32'h0);
        chk("a_rst_pc",   204, a_pc,        32'h0);
        chk("a_rst_ce",   204, 32'(a_ce),   32'h0);
        chk("a_rst_kill", 204, 32'(a_kill), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
